// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op/state encodings and iteration count for the Hi/Lo multiply unit.
`default_nettype none

package hilo_pkg;

    localparam int MUL_ITER = 32;
    localparam int OP_W     = 3;
    localparam int CNT_W    = $clog2(MUL_ITER);

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MADD  = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_mul32_core.sv
// seq_mul32_core: unsigned 32x32 shift-add multiplier, one partial product per step.
`default_nettype none

module seq_mul32_core
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic [63:0] acc_o,
    output logic        last_o
);

    logic [63:0]      mcand_q;
    logic [31:0]      mplier_q;
    logic [63:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= {32'd0, mcand_i};
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = (cnt_q == CNT_W'(MUL_ITER - 1));

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: architectural Hi/Lo registers with MULT/MULTU/MADD/MSUB/MTHI/MTLO.
`default_nettype none

module hilo_muldiv_unit
    import hilo_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [OP_W-1:0] Op,
    input  logic [31:0]     A,
    input  logic [31:0]     B,
    output logic [63:0]     HiLo,
    output logic            Busy,
    output logic            Done
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic        neg_q, neg_d;
    logic [63:0] hilo_q, hilo_d;
    logic        done_q;

    op_e         w_op;
    logic        w_signed;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_load, w_step, w_last;
    logic [63:0] w_acc, w_prod;

    assign w_op     = op_e'(Op);
    assign w_signed = (w_op != OP_MULTU);
    assign w_mag_a  = (w_signed && A[31]) ? (32'd0 - A) : A;
    assign w_mag_b  = (w_signed && B[31]) ? (32'd0 - B) : B;
    assign w_prod   = neg_q ? (64'd0 - w_acc) : w_acc;

    seq_mul32_core u_core (
        .clk      (Clk),
        .rst_n    (Reset),
        .load_i   (w_load),
        .step_i   (w_step),
        .mcand_i  (w_mag_a),
        .mplier_i (w_mag_b),
        .acc_o    (w_acc),
        .last_o   (w_last)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hilo_d  = hilo_q;
        w_load  = 1'b0;
        w_step  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (w_op)
                        OP_MTHI: hilo_d[63:32] = A;
                        OP_MTLO: hilo_d[31:0]  = A;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            w_load  = 1'b1;
                            op_d    = w_op;
                            neg_d   = w_signed & (A[31] ^ B[31]);
                            state_d = S_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                w_step = 1'b1;
                if (w_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                // Accumulate forms wrap modulo 2^64 with no overflow indication.
                case (op_q)
                    OP_MADD: hilo_d = hilo_q + w_prod;
                    OP_MSUB: hilo_d = hilo_q - w_prod;
                    default: hilo_d = w_prod;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            neg_q   <= 1'b0;
            hilo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hilo_q  <= hilo_d;
            done_q  <= (state_q == S_FIN);
        end
    end

    assign HiLo = hilo_q;
    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench for the Hi/Lo multiply unit.
`default_nettype none

module tb_hilo_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] HiLo;
    logic        Busy;
    logic        Done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_hilo = '0;
    logic [63:0] exp_q[$];
    logic        busy_seen = 1'b0;

    hilo_muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .HiLo  (HiLo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Busy) busy_seen <= 1'b1;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            3'd1:    return sp;
            3'd2:    return up;
            3'd3:    return h + sp;
            3'd4:    return h - sp;
            3'd5:    return {a, h[31:0]};
            3'd6:    return {h[63:32], a};
            default: return h;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0; Op = 3'd0;
    endtask

    // Issue a multiply-class op, then wait for Done and check timing and scoreboard.
    task automatic run_mul(input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        int done_edge;
        int busy_cnt;
        logic [63:0] exp;
        logic [63:0] pre;
        model_hilo = model(op, a, b, model_hilo);
        exp_q.push_back(model_hilo);
        issue(op, a, b);
        pre = HiLo;
        done_edge = -1;
        busy_cnt  = Busy ? 1 : 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge Clk); #1;
            if (Done) begin done_edge = n; break; end
            if (Busy) busy_cnt++;
            if (HiLo !== pre) begin
                n_checks++; n_fail++;
                $display("FAIL %s hilo_stable: HiLo changed to %h during MUL, required %h", name, HiLo, pre);
                break;
            end
        end
        n_checks++;
        if (done_edge !== 33) begin
            n_fail++;
            $display("FAIL %s done_edge: got %0d, required 33", name, done_edge);
        end
        n_checks++;
        if (busy_cnt !== 33 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_window: high %0d samples (edges 0..32), Busy at done=%b, required 33 and 0",
                     name, busy_cnt, Busy);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (HiLo !== exp) begin
            n_fail++;
            $display("FAIL %s hilo: got %h, required %h", name, HiLo, exp);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: Done=%b one cycle later, required 0", name, Done);
        end
    endtask

    task automatic test_reset;
        #2;
        @(posedge Clk); #1;
        n_checks++;
        if (HiLo !== 64'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: HiLo=%h Busy=%b Done=%b, required 0/0/0", HiLo, Busy, Done);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_mthi_mtlo;
        busy_seen = 1'b0;
        issue(3'd5, 32'hDEADBEEF, 32'h0);
        model_hilo = model(3'd5, 32'hDEADBEEF, 32'h0, model_hilo);
        issue(3'd6, 32'h12345678, 32'h0);
        model_hilo = model(3'd6, 32'h12345678, 32'h0, model_hilo);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge Clk);
        n_checks++;
        if (HiLo !== 64'hDEADBEEF_12345678) begin
            n_fail++;
            $display("FAIL mthi_mtlo: HiLo=%h, required deadbeef12345678", HiLo);
        end
        n_checks++;
        if (busy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_mtlo_busy: Busy rose=%b, required 0", busy_seen);
        end
    endtask

    task automatic test_mult;
        run_mul("mult_neg1x2", 3'd1, 32'hFFFFFFFF, 32'h00000002);
        n_checks++;
        if (HiLo !== 64'hFFFFFFFF_FFFFFFFE) begin
            n_fail++;
            $display("FAIL mult_neg1x2_const: HiLo=%h, required fffffffffffffffe", HiLo);
        end
        run_mul("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++;
        if (HiLo !== 64'hFFFFFFFE_00000001) begin
            n_fail++;
            $display("FAIL multu_max_const: HiLo=%h, required fffffffe00000001", HiLo);
        end
        run_mul("mult_minmin", 3'd1, 32'h80000000, 32'h80000000);
        n_checks++;
        if (HiLo !== 64'h40000000_00000000) begin
            n_fail++;
            $display("FAIL mult_minmin_const: HiLo=%h, required 4000000000000000", HiLo);
        end
        run_mul("mult_zero", 3'd1, 32'h0, 32'h89ABCDEF);
    endtask

    task automatic test_madd_msub;
        issue(3'd5, 32'd0, 32'd0);
        model_hilo = model(3'd5, 32'd0, 32'd0, model_hilo);
        issue(3'd6, 32'd10, 32'd0);
        model_hilo = model(3'd6, 32'd10, 32'd0, model_hilo);
        run_mul("madd", 3'd3, 32'd3, 32'd4);
        n_checks++;
        if (HiLo !== 64'd22) begin
            n_fail++;
            $display("FAIL madd_const: HiLo=%h, required 22", HiLo);
        end
        run_mul("msub", 3'd4, 32'd5, 32'd5);
        n_checks++;
        if (HiLo !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_fail++;
            $display("FAIL msub_const: HiLo=%h, required fffffffffffffffd", HiLo);
        end
        run_mul("madd_neg", 3'd3, 32'hFFFFFFF0, 32'd3);
    endtask

    task automatic test_busy_ignore;
        int done_edge;
        logic [63:0] exp;
        model_hilo = model(3'd1, 32'h00001234, 32'hFFFFFFFB, model_hilo);
        exp_q.push_back(model_hilo);
        issue(3'd1, 32'h00001234, 32'hFFFFFFFB);
        for (int i = 0; i < 12; i++) begin
            Start = 1'b1;
            Op    = (i == 0) ? 3'd6 : 3'($urandom_range(1, 6));
            A     = (i == 0) ? 32'h55 : $urandom;
            B     = $urandom;
            @(posedge Clk); #1;
        end
        Start = 1'b0; Op = 3'd0;
        done_edge = -1;
        for (int n = 13; n <= 60; n++) begin
            @(posedge Clk); #1;
            if (Done) begin done_edge = n; break; end
        end
        n_checks++;
        if (done_edge !== 33) begin
            n_fail++;
            $display("FAIL busy_ignore_done: got edge %0d, required 33", done_edge);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (HiLo !== exp) begin
            n_fail++;
            $display("FAIL busy_ignore_hilo: got %h, required %h", HiLo, exp);
        end
    endtask

    task automatic test_back_to_back;
        run_mul("b2b_first", 3'd1, 32'd7, 32'd9);
        n_checks++;
        if (HiLo[31:0] !== 32'd63) begin
            n_fail++;
            $display("FAIL mflo_63: Lo=%h, required 63", HiLo[31:0]);
        end
        run_mul("b2b_second", 3'd2, 32'hCAFEBABE, 32'h00010001);
        run_mul("b2b_third", 3'd4, 32'h7FFFFFFF, 32'h80000001);
    endtask

    task automatic test_async_reset;
        int done_cnt;
        issue(3'd5, 32'd0, 32'd0);
        issue(3'd6, 32'd1, 32'd0);
        issue(3'd1, 32'd3, 32'd3);
        for (int i = 0; i < 9; i++) @(posedge Clk);
        #3;
        Reset = 1'b0;
        #0.5;
        n_checks++;
        if (HiLo !== 64'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: HiLo=%h Busy=%b Done=%b, required 0/0/0", HiLo, Busy, Done);
        end
        #0.5;
        Reset = 1'b1;
        model_hilo = '0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0 || HiLo !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_abort: Done pulses=%0d HiLo=%h, required 0 and 0", done_cnt, HiLo);
        end
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_madd_msub();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
